bus_rr_router: RTL and testbench

- Synthesizable next-generation shared-bus generator/arbiter for the terminal bus.
- N terminal FIFOs present pending packets. The block grants one at a time in round-robin order, pops the packet, and decodes the destination ID from the packet header.
- Delivers the packet to one terminal or to all terminals (broadcast), honouring per-terminal receive backpressure, which the previous generation lacked.
- Sits between the terminal-side driver FIFOs and the receive FIFOs. Keeps packet/drop statistics.

---
 rtl/bus_rr_router.sv | 175 +++++++++++++++++
 tb/tb_bus_rr_router.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_router.sv
// Round-robin shared-bus arbiter: grants one pending terminal, pops its packet and
// delivers it unicast or broadcast under receive backpressure. Optional macro: BUS_RR_WDOG_EN.
module bus_rr_router #(
    parameter int              drvrs     = 5,
    parameter int              pckg_sz   = 16,
    parameter int              id_w      = 8,
    parameter logic [id_w-1:0] broadcast = {id_w{1'b1}},
    parameter int              wd_cycles = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [drvrs-1:0]         pndng,
    input  logic [drvrs*pckg_sz-1:0] D_pop,
    output logic [drvrs-1:0]         pop,
    input  logic [drvrs-1:0]         full,
    output logic [drvrs-1:0]         push,
    output logic [pckg_sz-1:0]       D_push,
    output logic                     busy,
    output logic [15:0]              pkt_cnt,
    output logic [15:0]              drop_cnt
);

    localparam int GW = (drvrs > 1) ? $clog2(drvrs) : 1;

    if (drvrs < 2 || drvrs > 16 || pckg_sz < id_w + 1 || wd_cycles < 1) begin : g_cfg_err
        $error("bus_rr_router: unsupported parameter set");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_POP, ST_WAIT, ST_PUSH} state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [pckg_sz-1:0]   pkt_q, pkt_d;
    logic [drvrs-1:0]     mask_q, mask_d;
    logic [15:0]          pkt_cnt_q, pkt_cnt_d;
    logic [15:0]          drop_cnt_q, drop_cnt_d;

    logic [GW-1:0]        rr_hi, rr_lo, rr_idx;
    logic                 rr_hit_hi;
    logic [id_w-1:0]      dest;
    logic [drvrs-1:0]     grant_oh;
    logic [drvrs-1:0]     tgt;
    logic                 tgt_ok;

`ifdef BUS_RR_WDOG_EN
    localparam int WCW = $clog2(wd_cycles + 1);
    logic [WCW-1:0]       wcnt_q, wcnt_d;
`endif

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // grant_q doubles as last_grant: the search starts just after it and wraps.
    always_comb begin
        rr_hi     = '0;
        rr_lo     = '0;
        rr_hit_hi = 1'b0;
        for (int i = drvrs - 1; i >= 0; i--) begin
            if (pndng[i]) begin
                rr_lo = GW'(i);
                if (GW'(i) > grant_q) begin
                    rr_hi     = GW'(i);
                    rr_hit_hi = 1'b1;
                end
            end
        end
        rr_idx = rr_hit_hi ? rr_hi : rr_lo;
    end

    always_comb begin
        dest = pkt_q[pckg_sz-1 -: id_w];
        for (int i = 0; i < drvrs; i++) begin
            grant_oh[i] = (grant_q == GW'(i));
        end
        tgt = '0;
        if (dest == broadcast) begin
            tgt    = ~grant_oh;
            tgt_ok = 1'b1;
        end else begin
            for (int i = 0; i < drvrs; i++) begin
                tgt[i] = (dest == id_w'(i));
            end
            tgt_ok = |tgt;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        pkt_d      = pkt_q;
        mask_d     = mask_q;
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
`ifdef BUS_RR_WDOG_EN
        wcnt_d     = wcnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|pndng) begin
                    grant_d = rr_idx;
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                for (int i = 0; i < drvrs; i++) begin
                    if (grant_q == GW'(i)) pkt_d = D_pop[i*pckg_sz +: pckg_sz];
                end
`ifdef BUS_RR_WDOG_EN
                wcnt_d  = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!tgt_ok) begin
                    drop_cnt_d = sat_inc(drop_cnt_q);
                    state_d    = ST_IDLE;
                end else if ((tgt & full) == '0) begin
                    mask_d  = tgt;
                    state_d = ST_PUSH;
                end else begin
`ifdef BUS_RR_WDOG_EN
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_d == WCW'(wd_cycles)) begin
                        drop_cnt_d = sat_inc(drop_cnt_q);
                        state_d    = ST_IDLE;
                    end
`endif
                end
            end
            ST_PUSH: begin
                pkt_cnt_d = sat_inc(pkt_cnt_q);
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= GW'(drvrs - 1);
            pkt_q      <= '0;
            mask_q     <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            pkt_q      <= pkt_d;
            mask_q     <= mask_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

`ifdef BUS_RR_WDOG_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) wcnt_q <= '0;
        else        wcnt_q <= wcnt_d;
    end
`endif

    // Strobes come only from registered state so they cannot glitch on input changes.
    always_comb begin
        pop  = (state_q == ST_POP)  ? grant_oh : '0;
        push = (state_q == ST_PUSH) ? mask_q   : '0;
    end

    assign D_push   = pkt_q;
    assign busy     = (state_q != ST_IDLE);
    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bus_rr_router.sv
// Self-checking bench for bus_rr_router (default build, 5 terminals, 16-bit packets):
// vector table of single transactions plus round-robin, backpressure and reset sequences.
module tb_bus_rr_router;

    logic        clk;
    logic        reset;
    logic [4:0]  pndng;
    logic [79:0] d_pop;
    logic [4:0]  pop;
    logic [4:0]  full;
    logic [4:0]  push;
    logic [15:0] d_push;
    logic        busy;
    logic [15:0] pkt_cnt;
    logic [15:0] drop_cnt;

    bus_rr_router dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .pop(pop),
        .full(full), .push(push), .D_push(d_push), .busy(busy),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  mask;
        logic [15:0] data;
    } sb_ent_t;

    typedef struct {
        int          src;
        logic [15:0] data;
        logic [4:0]  exp_push;
    } vec_t;

    sb_ent_t sb[$];
    vec_t    vecs[9];
    int      n_vec  = 0;
    int      n_bad  = 0;
    int      exp_pkt  = 0;
    int      exp_drop = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every push must match the oldest outstanding expectation.
    always @(negedge clk) begin
        sb_ent_t e;
        if (reset && push != 5'b0) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_push", 32'(push), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_push_mask", 32'(push), 32'(e.mask));
                chk("sb_push_data", 32'(d_push), 32'(e.data));
            end
        end
    end

    task automatic chk_counts(input string nm);
        chk({nm, ".pkt_cnt"}, 32'(pkt_cnt), 32'(exp_pkt));
        chk({nm, ".drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
    endtask

    // Starts and ends on a falling edge; exp_push==0 means the packet must be dropped.
    task automatic run_pkt(input string nm, input int src, input logic [15:0] data,
                           input logic [4:0] exp_push);
        d_pop = '0;
        d_pop[src*16 +: 16] = data;
        full  = '0;
        pndng = 5'(1 << src);
        if (exp_push != 5'b0) sb.push_back('{exp_push, data});
        @(negedge clk);
        chk({nm, ".pop_c1"}, 32'(pop), 32'(1 << src));
        pndng = '0;
        @(negedge clk);
        chk({nm, ".busy_c2"}, 32'(busy), 32'd1);
        chk({nm, ".push_c2"}, 32'(push), 32'd0);
        @(negedge clk);
        chk({nm, ".push_c3"}, 32'(push), 32'(exp_push));
        chk({nm, ".dpush_c3"}, 32'(d_push), 32'(data));
        @(negedge clk);
        chk({nm, ".busy_c4"}, 32'(busy), 32'd0);
        if (exp_push != 5'b0) exp_pkt++;
        else                  exp_drop++;
        chk_counts(nm);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".pop"}, 32'(pop), 32'd0);
        chk({nm, ".push"}, 32'(push), 32'd0);
        chk({nm, ".busy"}, 32'(busy), 32'd0);
        chk({nm, ".dpush"}, 32'(d_push), 32'd0);
        chk({nm, ".pkt_cnt"}, 32'(pkt_cnt), 32'd0);
        chk({nm, ".drop_cnt"}, 32'(drop_cnt), 32'd0);
    endtask

    initial begin
        logic [4:0] got[5];
        logic [4:0] rr_exp[5];
        int         ngr;

        vecs[0] = '{2, 16'h03A5, 5'b01000};
        vecs[1] = '{1, 16'hFF12, 5'b11101};
        vecs[2] = '{0, 16'h0412, 5'b10000};
        vecs[3] = '{3, 16'h0300, 5'b01000};
        vecs[4] = '{4, 16'h0055, 5'b00001};
        vecs[5] = '{2, 16'h07C3, 5'b00000};
        vecs[6] = '{0, 16'h05AA, 5'b00000};
        vecs[7] = '{4, 16'hFFFF, 5'b01111};
        vecs[8] = '{0, 16'hFF00, 5'b11110};
        rr_exp  = '{5'b00001, 5'b00010, 5'b10000, 5'b00001, 5'b00010};

        reset = 1'b0;
        pndng = '0;
        full  = '0;
        d_pop = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset = 1'b1;

        for (int v = 0; v < 9; v++) begin
            run_pkt($sformatf("vec%0d", v), vecs[v].src, vecs[v].data, vecs[v].exp_push);
        end

        // Backpressure on the target, then only non-target terminals full.
        d_pop = '0;
        d_pop[0 +: 16] = 16'h0300;
        pndng = 5'b00001;
        full  = 5'b01000;
        sb.push_back('{5'b01000, 16'h0300});
        @(negedge clk);
        chk("bp.pop", 32'(pop), 32'd1);
        pndng = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp.hold_push", 32'(push), 32'd0);
            chk("bp.hold_busy", 32'(busy), 32'd1);
        end
        full = 5'b10111;
        @(negedge clk);
        chk("bp.release_push", 32'(push), 32'b01000);
        @(negedge clk);
        chk("bp.idle", 32'(busy), 32'd0);
        exp_pkt++;
        chk_counts("bp");

        // Round-robin from a fresh reset (last grant = 4).
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_pkt  = 0;
        exp_drop = 0;
        full  = '0;
        d_pop = '0;
        d_pop[0*16 +: 16] = 16'h0200;
        d_pop[1*16 +: 16] = 16'h0201;
        d_pop[4*16 +: 16] = 16'h0204;
        sb.push_back('{5'b00100, 16'h0200});
        sb.push_back('{5'b00100, 16'h0201});
        sb.push_back('{5'b00100, 16'h0204});
        sb.push_back('{5'b00100, 16'h0200});
        sb.push_back('{5'b00100, 16'h0201});
        pndng = 5'b10011;
        ngr = 0;
        for (int c = 0; c < 60 && ngr < 5; c++) begin
            @(negedge clk);
            if (pop != 5'b0) begin
                got[ngr] = pop;
                ngr++;
                if (ngr == 5) pndng = '0;
            end
        end
        pndng = '0;
        chk("rr.grants_seen", 32'(ngr), 32'd5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr.grant%0d", k), 32'(got[k]), 32'(rr_exp[k]));
        end
        repeat (6) @(negedge clk);
        exp_pkt = 5;
        chk_counts("rr");

        // Broadcast blocked by one full target, then reset asserted mid-WAIT.
        d_pop = '0;
        d_pop[1*16 +: 16] = 16'hFF12;
        full  = 5'b00001;
        pndng = 5'b00010;
        @(negedge clk);
        chk("rstw.pop", 32'(pop), 32'b00010);
        pndng = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rstw.hold_push", 32'(push), 32'd0);
            chk("rstw.hold_busy", 32'(busy), 32'd1);
        end
        #2 reset = 1'b0;
        #1 chk_zero("rstw.async");
        @(negedge clk);
        reset = 1'b1;
        full  = '0;
        exp_pkt  = 0;
        exp_drop = 0;
        for (int i = 0; i < 5; i++) d_pop[i*16 +: 16] = {8'h02, 8'(i)};
        sb.push_back('{5'b00100, 16'h0200});
        pndng = 5'b11111;
        @(negedge clk);
        chk("rstw.first_grant", 32'(pop), 32'b00001);
        pndng = '0;
        repeat (3) @(negedge clk);
        exp_pkt = 1;
        chk_counts("rstw.after");

        chk("sb.empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
